clint_regs: RTL and testbench
=============================

CLINT_REGS -- requirements
Module: clint_regs

Interface
REQ-001 Parameter NR_HARTS, default 1, number of harts served (range 1..64).
REQ-002 Parameter ADDR_WIDTH, default 64, width of the register-access address.
REQ-003 Parameter DATA_WIDTH, default 64, access data width (fixed at 64).
REQ-004 clk_i  input  1  single clock.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 rtc_i  input  1  asynchronous real-time-clock reference; its rising edge is the time base.
REQ-007 addr_i  input  ADDR_WIDTH  register address from the AXI-Lite slave front end.
REQ-008 en_i  input  1  access valid.
REQ-009 we_i  input  1  write when high, read when low (qualified by en_i).
REQ-010 wdata_i  input  64  write data.
REQ-011 rdata_o  output  64  read data.
REQ-012 timer_irq_o  output  NR_HARTS  machine timer interrupt, one bit per hart.
REQ-013 ipi_o  output  NR_HARTS  machine software interrupt, one bit per hart.

Function
REQ-014 Decoding uses only addr_i[15:0]; upper address bits shall be ignored.
REQ-015 The register map shall be:
- msip[h] at 0x0000+4h: 1 bit.
- mtimecmp[h] at 0x4000+8h: 64 bits.
- mtime at 0xBFF8: 64 bits.
REQ-016 rdata_o shall be combinational from addr_i and the current register state, valid in the same cycle as en_i=1, we_i=0; the front end samples it without an extra wait cycle.
REQ-017 rdata_o shall be 0 whenever en_i=0 or the address is unmapped.
REQ-018 msip decoding uses the 8-byte-aligned address:
- addr_i[2]=0 selects even hart 2k; read data in bit 0, write data from wdata_i[0].
- addr_i[2]=1 selects odd hart 2k+1; read data in bit 32, write data from wdata_i[32].
- A read shall return both harts of the pair: bit 0 = msip[2k], bit 32 = msip[2k+1].
REQ-019 mtimecmp and mtime accesses are full 64-bit; addr_i[2:0] shall be ignored for them.
REQ-020 A write (en_i=1, we_i=1) shall update the addressed register at the next clk_i edge. Writes to unmapped addresses, or to harts >= NR_HARTS, shall be ignored without error.
REQ-021 rtc_i shall pass through a 2-flop synchroniser followed by a rising-edge detector. Each detected edge increments mtime by 1, 3 or 4 clk_i cycles after the rtc_i rise.
REQ-022 mtime shall wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 with no side effect.
REQ-023 If a software write to mtime and an rtc tick occur in the same cycle, the written value is stored and the tick is dropped.
REQ-024 timer_irq_o[h] shall be registered, equal to (mtime >= mtimecmp[h]) unsigned, evaluated on the register values of the previous cycle. It asserts one cycle after the condition becomes true.
REQ-025 Clearing timer_irq_o shall happen only by writing mtimecmp or mtime. The interrupt is level, not sticky.
REQ-026 ipi_o[h] shall equal msip[h] directly (registered, no extra latency).
REQ-027 rtc_i toggling faster than clk_i/4 is out of scope; ticks may be lost.

Reset
REQ-028 On rst_i=1 at a clk_i edge:
- mtime = 0.
- all msip = 0.
- all mtimecmp = 0xFFFF_FFFF_FFFF_FFFF.
- timer_irq_o = 0, ipi_o = 0.
- synchroniser and edge-detector flops = 0.
REQ-029 Reset shall override any write or tick in the same cycle. An access in flight during reset is discarded.
REQ-030 rdata_o shall reflect the reset values in the first cycle after reset deasserts.

Structure
REQ-031 Package clint_pkg shall hold the offsets MSIP_BASE=0x0000, MTIMECMP_BASE=0x4000 and MTIME_OFFSET=0xBFF8, plus the 64-bit register typedef.
REQ-032 The synchroniser and edge detector shall be a single sub-module, clint_rtc_sync (clk_i, rst_i, rtc_i -> tick_o one-cycle pulse).
REQ-033 clint_regs shall connect directly to the en/we/address/data port set of the AXI-Lite slave front end, with no glue logic.

Verification
REQ-034 Reset, then read 0xBFF8, 0x4000 and 0x0000 -> 0, 0xFFFF_FFFF_FFFF_FFFF and 0, respectively; timer_irq_o=0.
REQ-035 Toggle rtc_i 10 rising edges at clk/8 -> mtime reads 10. Each increment occurs 3-4 cycles after its rtc_i rise.
REQ-036 Write mtimecmp[0]=5 and let mtime count from 0 -> timer_irq_o[0] rises exactly one cycle after mtime becomes 5. Then write mtimecmp[0]=100 -> irq clears on the following cycle.
REQ-037 NR_HARTS=2:
- write 0x0000 with 0x1 -> ipi_o=01.
- write 0x0004 with 0x1_0000_0000 -> ipi_o=11.
- read 0x0000 -> 0x0000_0001_0000_0001.
REQ-038 Same-cycle mtime write 0x10 and rtc tick -> mtime reads 0x10. Write mtime=0xFFFF_FFFF_FFFF_FFFF, then one tick -> reads 0.
REQ-039 Read 0x8000 and write 0x8000 -> read returns 0 and register state is unchanged. Assert rst_i during a write cycle -> the write is lost and the reset values hold.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared register-map offsets and data types for the core-local interruptor
// register block.
package clint_pkg;

  typedef logic [63:0] reg64_t;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_OFFSET  = 16'hBFF8;

  // Compare value that keeps a hart's timer interrupt quiet out of reset.
  localparam reg64_t MTIMECMP_RST = '1;

endpackage

// File: rtl/clint_regs_if.sv
// Register-access port set shared with the AXI-Lite slave front end:
// single-cycle enable/write strobe, address, write data and same-cycle read data.
interface clint_regs_if
  import clint_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  en_i;
  logic                  we_i;
  reg64_t                wdata_i;
  reg64_t                rdata_o;

  modport master (
    output addr_i, en_i, we_i, wdata_i,
    input  rdata_o
  );

  modport slave (
    input  addr_i, en_i, we_i, wdata_i,
    output rdata_o
  );

endinterface

// File: rtl/clint_rtc_sync.sv
// Brings the asynchronous real-time-clock reference into the clk_i domain and
// emits a one-cycle tick for each rising edge.
module clint_rtc_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rtc_i,
  output logic tick_o
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its source, which is what keeps this a true shift chain.
      r_sync <= {r_sync[0], rtc_i};
      r_prev <= r_sync[1];
    end
  end

  assign tick_o = r_sync[1] & ~r_prev;

endmodule

// File: rtl/clint_regs.sv
// Machine timer / software-interrupt registers: msip, per-hart mtimecmp and a
// shared mtime counter driven by the synchronised rtc reference.
module clint_regs
  import clint_pkg::*;
#(
  parameter int NR_HARTS   = 1,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rtc_i,
  clint_regs_if.slave         bus,
  output logic [NR_HARTS-1:0] timer_irq_o,
  output logic [NR_HARTS-1:0] ipi_o
);

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;
  logic                  w_tick;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_sel_msip;
  logic                  w_sel_cmp;
  logic                  w_sel_mtime;
  logic [11:0]           w_msip_idx;
  logic [10:0]           w_pair_idx;

  reg64_t                r_mtime;
  reg64_t                r_mtimecmp [NR_HARTS];
  logic [NR_HARTS-1:0]   r_msip;
  logic [NR_HARTS-1:0]   r_irq;

  clint_rtc_sync u_rtc_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rtc_i  (rtc_i),
    .tick_o (w_tick)
  );

  // Only the low 16 address bits decode; the rest are deliberately ignored.
  assign w_addr   = bus.addr_i;
  assign w_unused = ^w_addr;

  assign w_wr = bus.en_i & bus.we_i;
  assign w_rd = bus.en_i & ~bus.we_i;

  assign w_sel_msip  = (w_addr[15:14] == MSIP_BASE[15:14]);
  assign w_sel_cmp   = (w_addr[15:14] == MTIMECMP_BASE[15:14]);
  assign w_sel_mtime = (w_addr[15:3]  == MTIME_OFFSET[15:3]);
  assign w_msip_idx  = w_addr[13:2];
  assign w_pair_idx  = w_addr[13:3];

  // msip reads return the even/odd hart pair sharing one 8-byte word.
  always_comb begin
    // NOTE: the default assignment first means every path drives w_rdata,
    // so no latch is inferred even though most branches leave it alone.
    w_rdata = '0;
    if (w_rd) begin
      if (w_sel_mtime) w_rdata = r_mtime;
      for (int h = 0; h < NR_HARTS; h++) begin
        if (w_sel_msip && int'(w_pair_idx) == h / 2) begin
          if (h % 2 == 0) w_rdata[0]  = r_msip[h];
          else            w_rdata[32] = r_msip[h];
        end
        if (w_sel_cmp && int'(w_pair_idx) == h) w_rdata = r_mtimecmp[h];
      end
    end
  end

  assign bus.rdata_o = w_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime <= '0;
      r_msip  <= '0;
      r_irq   <= '0;
      // NOTE: the compare array is plain flops, not a RAM, so every entry
      // takes its reset value here.
      for (int h = 0; h < NR_HARTS; h++) r_mtimecmp[h] <= MTIMECMP_RST;
    end else begin
      if (w_wr && w_sel_mtime) r_mtime <= bus.wdata_i;
      else if (w_tick)         r_mtime <= r_mtime + 64'd1;

      for (int h = 0; h < NR_HARTS; h++) begin
        if (w_wr && w_sel_msip && int'(w_msip_idx) == h)
          r_msip[h] <= w_addr[2] ? bus.wdata_i[32] : bus.wdata_i[0];
        if (w_wr && w_sel_cmp && int'(w_pair_idx) == h)
          r_mtimecmp[h] <= bus.wdata_i;
        r_irq[h] <= (r_mtime >= r_mtimecmp[h]);
      end
    end
  end

  assign timer_irq_o = r_irq;
  assign ipi_o       = r_msip;

endmodule

// File: tb/tb_clint_regs.sv
// Directed bench for clint_regs with two harts: a register-map vector table
// followed by hand-written reset, rtc, timer-interrupt and wrap sequences.
module tb_clint_regs;
  import clint_pkg::*;

  localparam int NH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rtc = 1'b0;
  logic [NH-1:0] timer_irq;
  logic [NH-1:0] ipi;

  clint_regs_if #(.ADDR_WIDTH(64)) bus ();

  clint_regs #(.NR_HARTS(NH), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rtc_i       (rtc),
    .bus         (bus),
    .timer_irq_o (timer_irq),
    .ipi_o       (ipi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          we;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic [63:0]   exp_rd;
    logic [NH-1:0] exp_ipi;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CMP1 = 64'h1234_5678_9ABC_DEF0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic we, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] exp_rd,
                              input logic [NH-1:0] exp_ipi);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_ipi = exp_ipi;
    return v;
  endfunction

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    bus.en_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
    @(negedge clk);
    bus.en_i = 1'b0; bus.we_i = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] d);
    @(negedge clk);
    bus.en_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
    #1 d = bus.rdata_o;
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] exp_mtime;
    int          lat, c5, ci;

    bus.en_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;

    vecs.push_back(mk(1, 0, 64'hBFF8, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 64'h4000, 0, ONES, 2'b00));
    vecs.push_back(mk(1, 0, 64'h0000, 0, 0, 2'b00));
    vecs.push_back(mk(1, 0, 64'h4008, 0, ONES, 2'b00));
    vecs.push_back(mk(1, 1, 64'h0000, 64'h1, 0, 2'b01));
    vecs.push_back(mk(1, 1, 64'h0004, 64'h1_0000_0000, 0, 2'b11));
    vecs.push_back(mk(1, 0, 64'h0000, 0, 64'h0000_0001_0000_0001, 2'b11));
    vecs.push_back(mk(1, 0, 64'h0004, 0, 64'h0000_0001_0000_0001, 2'b11));
    vecs.push_back(mk(0, 0, 64'h0000, 0, 0, 2'b11));
    vecs.push_back(mk(1, 1, 64'h0000, 64'h1_0000_0000, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'h0000, 0, 64'h0000_0001_0000_0000, 2'b10));
    vecs.push_back(mk(1, 1, 64'h4008, CMP1, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'h4008, 0, CMP1, 2'b10));
    vecs.push_back(mk(1, 0, 64'hFFFF_0000_0000_4008, 0, CMP1, 2'b10));
    vecs.push_back(mk(1, 0, 64'h400C, 0, CMP1, 2'b10));
    vecs.push_back(mk(1, 1, 64'h0008, 64'h1, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'h0008, 0, 0, 2'b10));
    vecs.push_back(mk(1, 1, 64'h4010, 64'h7, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'h4010, 0, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'h4000, 0, ONES, 2'b10));
    vecs.push_back(mk(1, 1, 64'h8000, 64'hDEAD, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'h8000, 0, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'hBFF8, 0, 0, 2'b10));
    vecs.push_back(mk(1, 1, 64'hBFF8, 64'h20, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'hBFFC, 0, 64'h20, 2'b10));

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Register-map table; rtc held low so mtime only changes by writes.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.en_i = vecs[i].en; bus.we_i = vecs[i].we;
      bus.addr_i = vecs[i].addr; bus.wdata_i = vecs[i].wdata;
      #1;
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), bus.rdata_o, vecs[i].exp_rd);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ipi", i), 64'(ipi), 64'(vecs[i].exp_ipi));
      check($sformatf("vec%0d_irq", i), 64'(timer_irq), 64'd0);
    end
    @(negedge clk);
    bus.en_i = 1'b0; bus.we_i = 1'b0;

    // Reset asserted during a write cycle: the write is lost.
    @(negedge clk);
    rst = 1'b1;
    bus.en_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 64'hBFF8; bus.wdata_i = 64'h55;
    @(negedge clk);
    rst = 1'b0; bus.en_i = 1'b0; bus.we_i = 1'b0;
    rd(64'hBFF8, d); check("rst_wr_mtime", d, 64'h0);
    rd(64'h4008, d); check("rst_mtimecmp1", d, ONES);
    rd(64'h0000, d); check("rst_msip", d, 64'h0);
    check("rst_ipi", 64'(ipi), 64'd0);
    check("rst_irq", 64'(timer_irq), 64'd0);

    // Ten rtc rising edges at clk/8; each increment lands 3-4 cycles later.
    rd(64'hBFF8, d);
    exp_mtime = 64'd0;
    for (int p = 0; p < 10; p++) begin
      lat = 0;
      @(negedge clk);
      rtc = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        if (lat == 0 && bus.rdata_o == exp_mtime + 64'd1) lat = c;
        if (c == 4) begin
          @(negedge clk);
          rtc = 1'b0;
        end
      end
      check($sformatf("rtc_lat%0d_in_3_4", p), 64'(lat >= 3 && lat <= 4), 64'd1);
      exp_mtime = exp_mtime + 64'd1;
    end
    rd(64'hBFF8, d); check("rtc_count10", d, 64'd10);

    // Timer interrupt rises exactly one cycle after mtime reaches mtimecmp.
    wr(64'hBFF8, 64'h0);
    wr(64'h4000, 64'h5);
    rd(64'hBFF8, d);
    check("irq_low_before", 64'(timer_irq[0]), 64'd0);
    c5 = -1; ci = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      rtc = ((cyc % 8) < 4);
      @(posedge clk); #1;
      if (c5 < 0 && bus.rdata_o == 64'd5) c5 = cyc;
      if (ci < 0 && timer_irq[0]) ci = cyc;
    end
    @(negedge clk);
    rtc = 1'b0;
    repeat (6) @(negedge clk);
    check("irq_seen_after_mtime5", 64'(c5 >= 0), 64'd1);
    check("irq_one_cycle_after", 64'(ci), 64'(c5 + 1));
    check("irq_hart1_quiet", 64'(timer_irq[1]), 64'd0);

    // Raising mtimecmp clears the level interrupt on the following cycle.
    wr(64'h4000, 64'd100);
    check("irq_still_set", 64'(timer_irq[0]), 64'd1);
    @(posedge clk); #1;
    check("irq_cleared", 64'(timer_irq[0]), 64'd0);

    // mtime write wins over an rtc tick in the same cycle.
    @(negedge clk);
    rtc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.en_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 64'hBFF8; bus.wdata_i = 64'h10;
    @(negedge clk);
    bus.en_i = 1'b0; bus.we_i = 1'b0;
    repeat (3) @(negedge clk);
    rtc = 1'b0;
    repeat (6) @(negedge clk);
    rd(64'hBFF8, d); check("wr_beats_tick", d, 64'h10);

    // mtime wraps from all ones to zero on one tick.
    wr(64'hBFF8, ONES);
    @(negedge clk);
    rtc = 1'b1;
    repeat (4) @(negedge clk);
    rtc = 1'b0;
    repeat (6) @(negedge clk);
    rd(64'hBFF8, d); check("mtime_wrap", d, 64'h0);

    @(negedge clk);
    bus.en_i = 1'b0;
    #1 check("rdata_idle_zero", bus.rdata_o, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
